// File: rtl/data_bus_arbiter_pkg.sv
// Shared definitions for the data bus arbiter and its round-robin selector.
package data_bus_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 20;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned WAIT_W     = 4;

    localparam logic GNT_M0 = 1'b0;
    localparam logic GNT_M1 = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/data_bus_arbiter_rr_pick2.sv
// Two-input round-robin selector: on a tie the master not granted last wins.
module rr_pick2
    import data_bus_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = GNT_M0;
        if (req0 && req1) begin
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = GNT_M1;
        end
    end

endmodule

// File: rtl/data_bus_arbiter.sv
// Round-robin arbiter sharing one tri-state data bus between two masters,
// sequencing a single access with a configurable wait and a one-cycle ack.
module data_bus_arbiter
    import data_bus_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] bus_addr,
    inout  wire  [DATA_W-1:0] bus_data,
    output logic              read,
    output logic              write,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   cnt_q, cnt_d;
    logic                gnt_q, gnt_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic                read_q, read_d, write_q, write_d, drive_q, drive_d;
    logic                ack0_q, ack0_d, ack1_q, ack1_d, busy_q, busy_d;
    logic                pick_valid, pick_id, in_access;

    rr_pick2 u_pick (
        .req0        (m0_req),
        .req1        (m1_req),
        .last_grant  (last_q),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    // Next state, latches, and the registered view of the next cycle's bus outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_ACCESS;
                    gnt_d   = pick_id;
                    we_d    = (pick_id == GNT_M1) ? m1_we    : m0_we;
                    addr_d  = (pick_id == GNT_M1) ? m1_addr  : m0_addr;
                    wdata_d = (pick_id == GNT_M1) ? m1_wdata : m0_wdata;
                    cnt_d   = WAIT_W'(WAIT_CYCLES);
                end
            end
            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        if (gnt_q == GNT_M1) rdata1_d = bus_data;
                        else                 rdata0_d = bus_data;
                    end
                end else begin
                    cnt_d = cnt_q - WAIT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                last_d  = gnt_q;
            end
            default: state_d = ST_IDLE;
        endcase

        in_access  = (state_d == ST_ACCESS);
        busy_d     = (state_d != ST_IDLE);
        bus_addr_d = in_access ? addr_d : '0;
        read_d     = in_access && !we_d;
        drive_d    = in_access && we_d;
        write_d    = in_access && we_d && (cnt_d == '0);
        ack0_d     = (state_d == ST_RESP) && (gnt_d == GNT_M0);
        ack1_d     = (state_d == ST_RESP) && (gnt_d == GNT_M1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gnt_q      <= GNT_M0;
            last_q     <= GNT_M1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            bus_addr_q <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            drive_q    <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
            bus_addr_q <= bus_addr_d;
            read_q     <= read_d;
            write_q    <= write_d;
            drive_q    <= drive_d;
            ack0_q     <= ack0_d;
            ack1_q     <= ack1_d;
            busy_q     <= busy_d;
        end
    end

    assign bus_data = drive_q ? wdata_q : {DATA_W{1'bz}};
    assign bus_addr = bus_addr_q;
    assign read     = read_q;
    assign write    = write_q;
    assign busy     = busy_q;
    assign m0_ack   = ack0_q;
    assign m1_ack   = ack1_q;
    assign m0_rdata = rdata0_q;
    assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench: two arbiters (no wait / two waits), each with a 16-word bench slave,
// checked against a transaction-level round-robin and memory model.
module tb_data_bus_arbiter;

    localparam int unsigned AW = 20;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset    [2];
    logic          m0_req   [2], m1_req [2], m0_we [2], m1_we [2];
    logic [AW-1:0] m0_addr  [2], m1_addr [2];
    logic [DW-1:0] m0_wdata [2], m1_wdata [2], m0_rdata [2], m1_rdata [2];
    logic          m0_ack   [2], m1_ack [2];
    logic [AW-1:0] bus_addr [2];
    logic          rd [2], wr [2], busy [2];
    logic [DW-1:0] bdo [2], peek [2];
    logic [3:0]    peek_addr;
    logic          init_mem;

    int            errors = 0;
    int            checks = 0;
    int            wt     [2];
    int            last   [2];
    logic [DW-1:0] ref_mem [2][16];

    function automatic logic [DW-1:0] init_word(input int i);
        return (i == 5) ? 16'h1234 : 16'(32'hA000 + i * 32'h0111);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        wire  [DW-1:0] bd;
        logic [DW-1:0] smem [16];

        data_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(g == 0 ? 0 : 2)) u_dut (
            .clk      (clk),
            .reset    (reset[g]),
            .m0_req   (m0_req[g]),
            .m0_we    (m0_we[g]),
            .m0_addr  (m0_addr[g]),
            .m0_wdata (m0_wdata[g]),
            .m0_rdata (m0_rdata[g]),
            .m0_ack   (m0_ack[g]),
            .m1_req   (m1_req[g]),
            .m1_we    (m1_we[g]),
            .m1_addr  (m1_addr[g]),
            .m1_wdata (m1_wdata[g]),
            .m1_rdata (m1_rdata[g]),
            .m1_ack   (m1_ack[g]),
            .bus_addr (bus_addr[g]),
            .bus_data (bd),
            .read     (rd[g]),
            .write    (wr[g]),
            .busy     (busy[g])
        );

        // Slave: asynchronous read, write on the rising edge.
        assign bd = (rd[g] && bus_addr[g] < 20'd16) ? smem[bus_addr[g][3:0]] : {DW{1'bz}};
        always @(posedge clk) begin
            if (init_mem) begin
                for (int i = 0; i < 16; i++) smem[i] <= init_word(i);
            end else if (wr[g] && bus_addr[g] < 20'd16) begin
                smem[bus_addr[g][3:0]] <= bd;
            end
        end
        assign peek[g] = smem[peek_addr];
        assign bdo[g]  = bd;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d);
        reset[d]  = 1'b1;
        m0_req[d] = 1'b0;
        m1_req[d] = 1'b0;
        step();
        step();
        reset[d] = 1'b0;
        last[d]  = 1;
        chk("rst_busy",  32'(busy[d]), 32'd0);
        chk("rst_ack0",  32'(m0_ack[d]), 32'd0);
        chk("rst_ack1",  32'(m1_ack[d]), 32'd0);
        chk("rst_strb",  32'({rd[d], wr[d]}), 32'd0);
        chk("rst_addr",  32'(bus_addr[d]), 32'd0);
        chk("rst_rdat0", 32'(m0_rdata[d]), 32'd0);
        chk("rst_rdat1", 32'(m1_rdata[d]), 32'd0);
    endtask

    // One arbitration round: requesters hold req until acked, then drop it.
    task automatic run_round(input int d, input logic r0, input logic r1,
                             input logic we0, input logic we1,
                             input logic [3:0] a0, input logic [3:0] a1,
                             input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic scramble);
        logic          twe [2];
        logic [3:0]    ta  [2];
        logic [DW-1:0] tw  [2];
        int order [2];
        int n, idx, k, drop, cur, ak, w;
        int strobe_bad, busy_bad, addr_bad, data_bad, extra_ack;
        logic er, ew, eb, a0s, a1s;

        w = wt[d];
        twe[0] = we0; twe[1] = we1; ta[0] = a0; ta[1] = a1; tw[0] = w0; tw[1] = w1;
        order[0] = 0; order[1] = 1; n = 0;
        if (r0 && r1) begin
            order[0] = (last[d] == 1) ? 0 : 1;
            order[1] = 1 - order[0];
            n = 2;
        end else if (r0) begin
            order[0] = 0; n = 1;
        end else if (r1) begin
            order[0] = 1; n = 1;
        end

        m0_we[d] = we0; m0_addr[d] = 20'(a0); m0_wdata[d] = w0; m0_req[d] = r0;
        m1_we[d] = we1; m1_addr[d] = 20'(a1); m1_wdata[d] = w1; m1_req[d] = r1;

        idx = 0; k = 0; drop = -1;
        strobe_bad = 0; busy_bad = 0; addr_bad = 0; data_bad = 0; extra_ack = 0;
        while ((idx < n || drop >= 0) && k < 60) begin
            step();
            k++;
            if (drop == 0) m0_req[d] = 1'b0;
            else if (drop == 1) m1_req[d] = 1'b0;
            drop = -1;

            // Expected bus timeline for the master currently being served.
            er = 1'b0; ew = 1'b0; eb = 1'b0;
            cur = (idx < n) ? order[idx] : 0;
            if (idx < n) begin
                ak = 2 + w + idx * (3 + w);
                eb = (k >= ak - 1 - w) && (k <= ak);
                er = !twe[cur] && (k >= ak - 1 - w) && (k <= ak - 1);
                ew = twe[cur] && (k == ak - 1);
            end
            if (rd[d] !== er || wr[d] !== ew) strobe_bad++;
            if (busy[d] !== eb) busy_bad++;
            if ((rd[d] || wr[d]) && idx < n) begin
                if (bus_addr[d] !== 20'(ta[cur])) addr_bad++;
                if (wr[d] && bdo[d] !== tw[cur]) data_bad++;
                if (scramble) begin
                    if (cur == 0) begin
                        m0_addr[d] = 20'(ta[0] + 4'd1); m0_wdata[d] = ~tw[0]; m0_we[d] = ~twe[0];
                    end else begin
                        m1_addr[d] = 20'(ta[1] + 4'd1); m1_wdata[d] = ~tw[1]; m1_we[d] = ~twe[1];
                    end
                end
            end

            a0s = m0_ack[d];
            a1s = m1_ack[d];
            if (a0s || a1s) begin
                if (idx >= n || (a0s && a1s)) begin
                    extra_ack++;
                end else begin
                    cur = a1s ? 1 : 0;
                    chk($sformatf("ack_who_d%0d", d), 32'(cur), 32'(order[idx]));
                    chk($sformatf("ack_cycle_d%0d", d), 32'(k), 32'(2 + w + idx * (3 + w)));
                    if (!twe[cur])
                        chk($sformatf("rdata_d%0d_a%0d", d, ta[cur]),
                            32'(cur == 1 ? m1_rdata[d] : m0_rdata[d]), 32'(ref_mem[d][ta[cur]]));
                    else
                        ref_mem[d][ta[cur]] = tw[cur];
                    drop = cur;
                    idx++;
                end
            end
        end
        chk("served",     32'(idx), 32'(n));
        chk("strobes",    32'(strobe_bad), 32'd0);
        chk("busy",       32'(busy_bad), 32'd0);
        chk("bus_addr",   32'(addr_bad), 32'd0);
        chk("bus_wdata",  32'(data_bad), 32'd0);
        chk("extra_ack",  32'(extra_ack), 32'd0);
        if (n > 0) last[d] = order[n - 1];
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        int bad;
        logic r0, r1;

        wt[0] = 0; wt[1] = 2;
        peek_addr = 4'd0;
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b1;
            m0_req[d] = 1'b0; m1_req[d] = 1'b0; m0_we[d] = 1'b0; m1_we[d] = 1'b0;
            m0_addr[d] = '0; m1_addr[d] = '0; m0_wdata[d] = '0; m1_wdata[d] = '0;
            for (int i = 0; i < 16; i++) ref_mem[d][i] = init_word(i);
        end
        init_mem = 1'b1;
        step();
        init_mem = 1'b0;
        do_reset(0);
        do_reset(1);

        // Single read, write then read-back, round-robin ties after reset.
        run_round(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 16'h0, 16'h0, 1'b0);
        run_round(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd3, 16'h0, 16'hBEEF, 1'b0);
        run_round(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd3, 4'd0, 16'h0, 16'h0, 1'b0);
        do_reset(0);
        run_round(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd3, 16'h0, 16'h0, 1'b0);
        run_round(0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 4'd5, 16'hC0DE, 16'h0, 1'b0);

        // Two wait cycles: read, write, and inputs changed during ACCESS.
        run_round(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 16'h0, 16'h0, 1'b0);
        run_round(1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd9, 16'h0, 16'h7A7A, 1'b0);
        run_round(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 16'h0, 16'h0, 1'b1);
        run_round(1, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd2, 16'h0, 16'h3C3C, 1'b1);

        // Reset during the first ACCESS cycle of a waited write.
        m0_we[1] = 1'b1; m0_addr[1] = 20'd7; m0_wdata[1] = 16'h5555; m0_req[1] = 1'b1;
        step();
        chk("mid_busy_pre", 32'(busy[1]), 32'd1);
        reset[1] = 1'b1;
        m0_req[1] = 1'b0;
        step();
        reset[1] = 1'b0;
        last[1]  = 1;
        chk("mid_busy",  32'(busy[1]), 32'd0);
        chk("mid_strb",  32'({rd[1], wr[1]}), 32'd0);
        chk("mid_ack",   32'({m0_ack[1], m1_ack[1]}), 32'd0);
        chk("mid_addr",  32'(bus_addr[1]), 32'd0);
        chk("mid_rdata", 32'(m0_rdata[1]), 32'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (wr[1] || m0_ack[1] || m1_ack[1] || busy[1]) bad++;
        end
        chk("mid_quiet", 32'(bad), 32'd0);
        peek_addr = 4'd7;
        #1;
        chk("mid_word7", 32'(peek[1]), 32'(ref_mem[1][7]));

        // Random rounds against the reference model.
        for (int it = 0; it < 40; it++) begin
            int d;
            d  = int'($urandom_range(0, 1));
            r0 = 1'($urandom_range(0, 1));
            r1 = r0 ? 1'($urandom_range(0, 1)) : 1'b1;
            run_round(d, r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                peek_addr = 4'(i);
                #1;
                chk($sformatf("mem_d%0d_a%0d", d, i), 32'(peek[d]), 32'(ref_mem[d][i]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
